serial_adder_16: RTL and testbench
==================================

# serial_adder_16

Bit-serial 16-bit adder/subtractor for the alu_16 datapath. It sits directly upstream of `full_adder_cell` and drives it: each clock cycle it feeds one operand bit pair and the registered carry into a single `full_adder_cell` instance, LSB first. It shifts the sum bit into a result register and runs under a start/done handshake. It trades throughput for area against the ripple-carry path.

## Interface
- `WIDTH`, 16, operand and result width in bits (≥2).
- `clk` input 1 — single clock; all state updates on the rising edge.
- `rst_n` input 1 — reset, synchronous and active-low.
- `start` input 1 — request an operation; sampled only when not busy.
- `sub` input 1 — 0 = x+y, 1 = x−y; captured with `start`.
- `x` input WIDTH — operand A; captured with `start`.
- `y` input WIDTH — operand B; captured with `start`.
- `busy` output 1 — operation in progress.
- `done` output 1 — one-cycle pulse when the result is valid.
- `z` output WIDTH — result; holds its value until the next accepted `start`.
- `c_out` output 1 — carry out of the MSB. For a subtract this is 1 when there is no borrow.
- `ovf` output 1 — two's-complement overflow flag.
- `zero` output 1 — flag set when `z == 0`.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN when `start`=1.
  - RUN→DONE after WIDTH bit steps.
  - DONE→RUN if `start`=1, otherwise DONE→IDLE.
- On accept:
  - Load the x shift register with x.
  - Load the y shift register with `y ^ {WIDTH{sub}}`.
  - Initialise the carry register to `sub`.
  - Clear the bit counter and the result register.
- Each RUN cycle:
  - `full_adder_cell` inputs are x_sr[0], y_sr[0] and the carry register.
  - Shift `z` into the result MSB, with the result register shifting right.
  - Register `c_out` into the carry register.
  - Shift both operand registers right.
  - Increment the counter.
- On the last bit step, latch:
  - `c_out` = final carry.
  - `ovf` = carry into MSB XOR carry out of MSB. This requires keeping the previous-cycle carry.
  - `zero` = (final result == 0).
- `start` while in RUN is ignored: no capture, no restart.
- `start` in the DONE cycle is accepted as a fresh operation. `done` still pulses that cycle.
- Modulo-2^WIDTH wrap: 0xFFFF + 0x0001 gives z = 0x0000 with `c_out` = 1.

## Timing
- Reset values: `busy`=0, `done`=0, `z`=0, `c_out`=0, `ovf`=0, `zero`=0. FSM state is IDLE, the counter is 0, all shift registers are 0.
- Let edge k be the edge that samples `start`=1.
  - `busy`=1 from after edge k through the last RUN cycle.
  - The WIDTH RUN cycles occupy edges k+1..k+WIDTH.
  - `done`=1 and `busy`=0 for exactly the one cycle after edge k+WIDTH, i.e. WIDTH cycles after acceptance.
- `z`, `c_out`, `ovf` and `zero` update only at edge k+WIDTH and hold until then.
- Back-to-back operations (start during DONE) give a throughput of one result per WIDTH+1 cycles.
- `rst_n`=0 mid-operation aborts at the next edge:
  - All outputs return to their reset values.
  - No `done` pulse is produced.
  - `start` is not sampled while `rst_n`=0.

## Configuration
- `SERIAL_ADDER_FLAGS_EN` defined:
  - `ovf` and `zero` are computed and latched as above.
  - The previous-carry register is present.
- Not defined:
  - `ovf` and `zero` are tied to 0.
  - The previous-carry register and zero-detect logic are removed.
  - Ports are unchanged; `z`, `c_out`, `busy` and `done` behave identically.

## Structure
- Shared package `alu_16_pkg` holds:
  - the `ALU_WIDTH` = 16 constant;
  - the FSM state typedef (IDLE/RUN/DONE);
  - the op-select constants `OP_ADD`=0 and `OP_SUB`=1.
- One sub-module: `full_adder_cell` (existing, ports x, y, c_in, z, c_out), instantiated once.
- Counter width is $clog2(WIDTH+1).

## Test plan
- x=0x0001, y=0x0001, sub=0 → done exactly 16 cycles after the accept edge; z=0x0002, c_out=0, ovf=0, zero=0.
- x=0xFFFF, y=0x0001, sub=0 → z=0x0000, c_out=1, zero=1, ovf=0. With the macro undefined: zero=0.
- x=0x7FFF, y=0x0001, sub=0 → z=0x8000, ovf=1, c_out=0.
- x=0x0005, y=0x0007, sub=1 → z=0xFFFE, c_out=0 (borrow). Then x=0x0007, y=0x0005, sub=1 → z=0x0002, c_out=1.
- x=0x1234, y=0x0001 accepted. Then start=1 with x=0xAAAA at cycle 5 of RUN → ignored; z=0x1235. Then start in the DONE cycle with x=0x0002, y=0x0003 → accepted; z=0x0005 after a further 16 cycles.
- Accept an operation, then drive rst_n=0 at RUN cycle 8 → next edge busy=0, done never pulses, z=0. After release, 0x0010+0x0020 → z=0x0030.

Source files
------------

// File: rtl/alu_16_pkg.sv
// Shared definitions for the alu_16 datapath: width, serial FSM states, op codes.
package alu_16_pkg;

  localparam int ALU_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder: z = x ^ y ^ c_in, c_out = majority(x, y, c_in).
module full_adder_cell (
  input  logic x,
  input  logic y,
  input  logic c_in,
  output logic z,
  output logic c_out
);

  // Sum and carry of one bit position.
  always_comb begin
    z     = x ^ y ^ c_in;
    c_out = (x & y) | (x & c_in) | (y & c_in);
  end

endmodule

// File: rtl/serial_adder_16.sv
// Bit-serial adder/subtractor, LSB first, one bit per clock through a single
// full_adder_cell. Start/done handshake; result and flags latched on the last
// bit step. Optional feature macro: SERIAL_ADDER_FLAGS_EN enables the ovf and
// zero flags; without it both are tied to 0.
module serial_adder_16
  import alu_16_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   x_sr;
  logic [WIDTH-1:0]   y_sr;
  logic [WIDTH-1:0]   res_sr;
  logic               carry_q;
  logic               fa_z;
  logic               fa_cout;
  logic               accept;
  logic               last_step;
  logic [WIDTH-1:0]   res_final;

  full_adder_cell u_fa (
    .x     (x_sr[0]),
    .y     (y_sr[0]),
    .c_in  (carry_q),
    .z     (fa_z),
    .c_out (fa_cout)
  );

  // Accept/step decode; res_final is the complete result as seen on the last step.
  always_comb begin
    accept    = start && (state_q != RUN);
    last_step = (state_q == RUN) && (cnt_q == CNT_W'(WIDTH - 1));
    res_final = {fa_z, res_sr[WIDTH-1:1]};
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic; start is ignored while RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // Operand capture and one bit step per RUN cycle; subtract is x + ~y + 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_sr    <= '0;
      y_sr    <= '0;
      res_sr  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      x_sr    <= x;
      y_sr    <= y ^ {WIDTH{sub}};
      res_sr  <= '0;
      carry_q <= sub;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      x_sr    <= x_sr >> 1;
      y_sr    <= y_sr >> 1;
      res_sr  <= res_final;
      carry_q <= fa_cout;
      cnt_q   <= cnt_q + CNT_W'(1);
    end
  end

  // Result and carry-out latch; holds until the next operation completes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      z     <= '0;
      c_out <= 1'b0;
    end else if (last_step) begin
      z     <= res_final;
      c_out <= fa_cout;
    end
  end

`ifdef SERIAL_ADDER_FLAGS_EN
  // Flag latch: on the last step carry_q still holds the previous cycle's
  // carry, i.e. the carry into the MSB, so ovf compares it with the carry out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else if (last_step) begin
      ovf  <= carry_q ^ fa_cout;
      zero <= (res_final == '0);
    end
  end
`else
  // Flags not built: tied low.
  always_comb begin
    ovf  = 1'b0;
    zero = 1'b0;
  end
`endif

endmodule

// File: tb/tb_serial_adder_16.sv
// Directed bench for serial_adder_16 with a scoreboard of expected results.
module tb_serial_adder_16;

  typedef struct packed {
    logic [15:0] z;
    logic        c;
    logic        v;
    logic        zf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic [15:0] x = '0;
  logic [15:0] y = '0;
  logic        busy;
  logic        done;
  logic [15:0] z;
  logic        c_out;
  logic        ovf;
  logic        zero;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] last_z = '0;

  serial_adder_16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .x     (x),
    .y     (y),
    .busy  (busy),
    .done  (done),
    .z     (z),
    .c_out (c_out),
    .ovf   (ovf),
    .zero  (zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic s);
    exp_t        e;
    logic [15:0] bb;
    logic [16:0] r;
    bb   = b ^ {16{s}};
    r    = {1'b0, a} + {1'b0, bb} + {16'd0, s};
    e.z  = r[15:0];
    e.c  = r[16];
`ifdef SERIAL_ADDER_FLAGS_EN
    e.v  = (a[15] == bb[15]) && (r[15] != a[15]);
    e.zf = (r[15:0] == 16'd0);
`else
    e.v  = 1'b0;
    e.zf = 1'b0;
`endif
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive an operation so it is sampled at the next rising edge.
  task automatic accept_op(input logic [15:0] a, input logic [15:0] b, input logic s, input bit push);
    x = a;
    y = b;
    sub = s;
    start = 1'b1;
    if (push) sb.push_back(model(a, b, s));
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  // Wait (bounded) for done, check latency, hold of z mid-run, and the result.
  task automatic wait_done(input string tag, input int n_exp);
    int   n;
    exp_t e;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (i == 8 && i < n_exp) chk({tag, "_z_hold"}, {16'd0, z}, {16'd0, last_z});
      if (done) begin
        n = i;
        break;
      end
    end
    chk({tag, "_latency"}, n, n_exp);
    if (n != 0) begin
      chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
      chk({tag, "_sb_depth"}, {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk({tag, "_z"}, {16'd0, z}, {16'd0, e.z});
        chk({tag, "_c_out"}, {31'd0, c_out}, {31'd0, e.c});
        chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, e.v});
        chk({tag, "_zero"}, {31'd0, zero}, {31'd0, e.zf});
        last_z = e.z;
      end
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_z", {16'd0, z}, 32'd0);
    chk("rst_c_out", {31'd0, c_out}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1 + 1
    accept_op(16'h0001, 16'h0001, 1'b0, 1'b1);
    wait_done("add_1_1", 16);
    @(posedge clk);
    #1;
    chk("done_one_cycle", {31'd0, done}, 32'd0);

    // Wrap to zero
    accept_op(16'hFFFF, 16'h0001, 1'b0, 1'b1);
    wait_done("add_wrap", 16);
    @(posedge clk);
    #1;

    // Signed overflow
    accept_op(16'h7FFF, 16'h0001, 1'b0, 1'b1);
    wait_done("add_ovf", 16);
    @(posedge clk);
    #1;

    // Subtract with and without borrow
    accept_op(16'h0005, 16'h0007, 1'b1, 1'b1);
    wait_done("sub_borrow", 16);
    @(posedge clk);
    #1;
    accept_op(16'h0007, 16'h0005, 1'b1, 1'b1);
    wait_done("sub_noborrow", 16);
    @(posedge clk);
    #1;

    // start during RUN ignored, then start in DONE accepted
    accept_op(16'h1234, 16'h0001, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    x = 16'hAAAA;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("ignored_start_busy", {31'd0, busy}, 32'd1);
    wait_done("ignore_start", 11);
    accept_op(16'h0002, 16'h0003, 1'b0, 1'b1);
    wait_done("back_to_back", 16);
    @(posedge clk);
    #1;

    // Reset mid-operation
    accept_op(16'h4321, 16'h1111, 1'b0, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_z", {16'd0, z}, 32'd0);
    chk("abort_c_out", {31'd0, c_out}, 32'd0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    rst_n = 1'b1;
    chk("start_in_reset_busy", {31'd0, busy}, 32'd0);
    last_z = 16'h0000;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done) chk("abort_no_done", {31'd0, done}, 32'd0);
    end
    chk("idle_after_abort", {31'd0, busy}, 32'd0);
    accept_op(16'h0010, 16'h0020, 1'b0, 1'b1);
    wait_done("after_reset", 16);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
